// File: rtl/st_buf_ctrl_pkg.sv
// Shared definitions for the store-buffer controller: store op encoding and
// the layout of one buffered bus write.
package st_buf_ctrl_pkg;

  // One-hot store type, bit order matches the load op encoding.
  localparam logic [3:0] ST_SD = 4'b0001;
  localparam logic [3:0] ST_SW = 4'b0010;
  localparam logic [3:0] ST_SH = 4'b0100;
  localparam logic [3:0] ST_SB = 4'b1000;

  // Word address field is sized for the widest supported address (64 bits).
  localparam int WADDR_W = 61;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [63:0]        data;
    logic [7:0]         strb;
  } st_entry_t;

endpackage

// File: rtl/st_fmt.sv
// Store formatter: places rs2 bytes into their lanes of the 8-byte bus word
// and flags misaligned or malformed store ops.
module st_fmt
  import st_buf_ctrl_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_data,
  output logic [63:0] fmt_data,
  output logic [7:0]  fmt_strb,
  output logic        misalign,
  output logic        illegal
);

  logic [5:0] lane_sh;
  assign lane_sh = {st_off, 3'b000};

  // More than one bit set is a malformed op.
  assign illegal = (st_op & (st_op - 4'd1)) != 4'd0;

  always_comb begin
    fmt_data = '0;
    fmt_strb = '0;
    misalign = 1'b0;
    case (st_op)
      ST_SD: begin
        fmt_data = st_data;
        fmt_strb = 8'hFF;
        misalign = st_off != 3'd0;
      end
      ST_SW: begin
        fmt_data = {32'b0, st_data[31:0]} << lane_sh;
        fmt_strb = 8'h0F << st_off;
        misalign = st_off[1:0] != 2'd0;
      end
      ST_SH: begin
        fmt_data = {48'b0, st_data[15:0]} << lane_sh;
        fmt_strb = 8'h03 << st_off;
        misalign = st_off[0];
      end
      ST_SB: begin
        fmt_data = {56'b0, st_data[7:0]} << lane_sh;
        fmt_strb = 8'h01 << st_off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/st_buf_ctrl.sv
// Store buffer controller: formats stores, queues them in order and drains
// them over a valid/ready write channel; flags loads that hit pending words.
module st_buf_ctrl
  import st_buf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [63:0]   st_data,
  output logic          st_stall,
  output logic          st_misalign,
  input  logic          ld_chk_en,
  input  logic [AW-1:0] ld_chk_addr,
  output logic          ld_hazard,
  output logic          buf_empty,
  output logic          mem_wr_valid,
  input  logic          mem_wr_ready,
  output logic [AW-1:0] mem_wr_addr,
  output logic [63:0]   mem_wr_data,
  output logic [7:0]    mem_wr_strb
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  st_entry_t        entry_q [DEPTH];
  st_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [63:0] fmt_data;
  logic [7:0]  fmt_strb;
  logic        fmt_misalign, fmt_illegal;
  logic        st_present, st_legal, enq, deq, ld_match;
  st_entry_t   new_ent, head;
  logic [2:0]  unused_ld_off;

  st_fmt u_fmt (
    .st_op    (st_op),
    .st_off   (st_addr[2:0]),
    .st_data  (st_data),
    .fmt_data (fmt_data),
    .fmt_strb (fmt_strb),
    .misalign (fmt_misalign),
    .illegal  (fmt_illegal)
  );

  assign unused_ld_off = ld_chk_addr[2:0];

  assign st_present  = st_op != 4'd0;
  assign st_misalign = st_present & (fmt_misalign | fmt_illegal);
  assign st_legal    = st_present & ~st_misalign;
  // A full buffer refuses even if the head drains this cycle; the core retries.
  assign enq         = st_legal & (count_q != FULL);
  assign st_stall    = st_legal & (count_q == FULL);

  assign buf_empty    = count_q == '0;
  assign mem_wr_valid = ~buf_empty;
  assign deq          = mem_wr_valid & mem_wr_ready;

  assign head        = entry_q[rd_ptr_q];
  assign mem_wr_addr = mem_wr_valid ? {head.waddr[AW-4:0], 3'b000} : '0;
  assign mem_wr_data = mem_wr_valid ? head.data : '0;
  assign mem_wr_strb = mem_wr_valid ? head.strb : '0;

  always_comb begin
    new_ent.waddr = WADDR_W'(st_addr[AW-1:3]);
    new_ent.data  = fmt_data;
    new_ent.strb  = fmt_strb;
  end

  always_comb begin
    ld_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && entry_q[i].waddr == WADDR_W'(ld_chk_addr[AW-1:3]))
        ld_match = 1'b1;
    end
  end
  assign ld_hazard = ld_chk_en & ld_match;

  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(deq);
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (enq) begin
      entry_d[wr_ptr_q] = new_ent;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entry_q  <= entry_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_st_buf_ctrl.sv
// Self-checking bench for st_buf_ctrl: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_st_buf_ctrl;

  localparam int DEPTH = 2;
  localparam int AW    = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    st_op = '0;
  logic [AW-1:0] st_addr = '0;
  logic [63:0]   st_data = '0;
  logic          st_stall, st_misalign;
  logic          ld_chk_en = 1'b0;
  logic [AW-1:0] ld_chk_addr = '0;
  logic          ld_hazard, buf_empty;
  logic          mem_wr_valid;
  logic          mem_wr_ready = 1'b0;
  logic [AW-1:0] mem_wr_addr;
  logic [63:0]   mem_wr_data;
  logic [7:0]    mem_wr_strb;

  st_buf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_op        (st_op),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_stall     (st_stall),
    .st_misalign  (st_misalign),
    .ld_chk_en    (ld_chk_en),
    .ld_chk_addr  (ld_chk_addr),
    .ld_hazard    (ld_hazard),
    .buf_empty    (buf_empty),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_strb  (mem_wr_strb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } ment_t;

  ment_t mq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-by-byte placement of the store into its lanes.
  function automatic void fmt_model(input logic [3:0] op, input logic [63:0] addr,
                                    input logic [63:0] d, output logic bad, output ment_t e);
    int sz;
    int off;
    case (op)
      4'b0001: sz = 8;
      4'b0010: sz = 4;
      4'b0100: sz = 2;
      4'b1000: sz = 1;
      default: sz = 0;
    endcase
    off    = int'(addr[2:0]);
    e.addr = {addr[63:3], 3'b000};
    e.data = '0;
    e.strb = '0;
    bad    = (op != 4'd0) && (sz == 0 || (off % sz) != 0);
    if (!bad) begin
      for (int k = 0; k < sz; k++) begin
        e.data[8*(off+k) +: 8] = d[8*k +: 8];
        e.strb[off+k]          = 1'b1;
      end
    end
  endfunction

  logic  m_bad, m_present, m_haz, m_enq, m_deq;
  ment_t m_ent, m_head;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      chk("rst_valid", mem_wr_valid, 0);
      chk("rst_empty", buf_empty, 1);
      chk("rst_addr", mem_wr_addr, 0);
      chk("rst_data", mem_wr_data, 0);
      chk("rst_strb", mem_wr_strb, 0);
      chk("rst_hazard", ld_hazard, 0);
    end else begin
      fmt_model(st_op, st_addr, st_data, m_bad, m_ent);
      m_present = st_op != 4'd0;
      chk("st_stall", st_stall, m_present && !m_bad && mq.size() == DEPTH);
      chk("st_misalign", st_misalign, m_present && m_bad);
      chk("wr_valid", mem_wr_valid, mq.size() != 0);
      chk("buf_empty", buf_empty, mq.size() == 0);
      if (mq.size() != 0) m_head = mq[0];
      else begin
        m_head.addr = '0; m_head.data = '0; m_head.strb = '0;
      end
      chk("wr_addr", mem_wr_addr, m_head.addr);
      chk("wr_data", mem_wr_data, m_head.data);
      chk("wr_strb", mem_wr_strb, m_head.strb);
      m_haz = 1'b0;
      foreach (mq[i]) if (mq[i].addr[63:3] == ld_chk_addr[63:3]) m_haz = 1'b1;
      chk("ld_hazard", ld_hazard, ld_chk_en && m_haz);
      m_deq = (mq.size() != 0) && mem_wr_ready;
      m_enq = m_present && !m_bad && (mq.size() < DEPTH);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back(m_ent);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] op, input logic [63:0] a, input logic [63:0] d);
    st_op   = op;
    st_addr = a;
    st_data = d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", buf_empty, 1);
    chk("reset_valid", mem_wr_valid, 0);
    #2 rst = 1'b1;
    step();

    // SB into lane 3 with ready high
    mem_wr_ready = 1'b1;
    put(4'b1000, 64'h1003, 64'hAB);
    #1 chk("sb_stall", st_stall, 0);
    step();
    st_op = '0;
    #1;
    chk("sb_valid", mem_wr_valid, 1);
    chk("sb_addr", mem_wr_addr, 64'h1000);
    chk("sb_strb", mem_wr_strb, 64'h08);
    chk("sb_data", mem_wr_data, 64'h00000000AB000000);
    step();
    chk("sb_drained", buf_empty, 1);

    // misaligned SW and SH are dropped
    put(4'b0010, 64'h2006, 64'h11223344);
    #1 chk("sw_misalign", st_misalign, 1);
    chk("sw_stall", st_stall, 0);
    step();
    put(4'b0100, 64'h2001, 64'h5566);
    #1 chk("sh_misalign", st_misalign, 1);
    step();
    st_op = '0;
    #1 chk("mis_valid", mem_wr_valid, 0);

    // fill with ready low, third store stalls
    mem_wr_ready = 1'b0;
    put(4'b0001, 64'h4000, 64'hD0D0D0D0D0D0D0D0);
    step();
    put(4'b0001, 64'h4008, 64'hD1D1D1D1D1D1D1D1);
    step();
    put(4'b0001, 64'h4010, 64'hD2D2D2D2D2D2D2D2);
    #1;
    chk("full_stall", st_stall, 1);
    chk("full_addr", mem_wr_addr, 64'h4000);
    step();
    chk("hold_stall", st_stall, 1);
    chk("hold_addr", mem_wr_addr, 64'h4000);
    chk("hold_data", mem_wr_data, 64'hD0D0D0D0D0D0D0D0);
    mem_wr_ready = 1'b1;
    step();
    chk("drain1_addr", mem_wr_addr, 64'h4008);
    chk("drain1_stall", st_stall, 0);
    step();
    st_op = '0;
    #1;
    chk("drain2_addr", mem_wr_addr, 64'h4010);
    chk("drain2_data", mem_wr_data, 64'hD2D2D2D2D2D2D2D2);
    step();
    chk("drain_empty", buf_empty, 1);

    // load hazard on a pending word
    mem_wr_ready = 1'b0;
    put(4'b0001, 64'h3010, 64'h0123456789ABCDEF);
    step();
    st_op = '0;
    ld_chk_en = 1'b1;
    ld_chk_addr = 64'h3014;
    #1 chk("haz_hit", ld_hazard, 1);
    ld_chk_addr = 64'h3018;
    #1 chk("haz_miss", ld_hazard, 0);
    ld_chk_en = 1'b0;
    mem_wr_ready = 1'b1;
    step();
    step();
    chk("haz_empty", buf_empty, 1);

    // back-to-back SB with ready high: count stays 1 across pointer wrap
    for (int i = 0; i < 6; i++) begin
      put(4'b1000, 64'h5000 + 64'(9 * i), 64'(i + 1));
      step();
      chk("wrap_addr", mem_wr_addr, 64'h5000 + 64'(8 * i));
      chk("wrap_strb", mem_wr_strb, 64'(8'h01 << i));
      chk("wrap_data", mem_wr_data, 64'(i + 1) << (8 * i));
    end
    st_op = '0;
    step();
    chk("wrap_empty", buf_empty, 1);

    // reset in the middle of a handshake with two entries queued
    mem_wr_ready = 1'b0;
    put(4'b0001, 64'h6000, 64'hAAAA);
    step();
    put(4'b0001, 64'h6008, 64'hBBBB);
    step();
    st_op = '0;
    mem_wr_ready = 1'b1;
    #1 chk("prerst_valid", mem_wr_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_valid", mem_wr_valid, 0);
    chk("midrst_strb", mem_wr_strb, 0);
    chk("midrst_data", mem_wr_data, 0);
    chk("midrst_addr", mem_wr_addr, 0);
    chk("midrst_empty", buf_empty, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    put(4'b0001, 64'h7000, 64'hCCCC);
    step();
    st_op = '0;
    #1;
    chk("postrst_addr", mem_wr_addr, 64'h7000);
    chk("postrst_data", mem_wr_data, 64'hCCCC);
    step();
    chk("postrst_empty", buf_empty, 1);

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [63:0] a;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: st_op = 4'b0000;
        3:       st_op = 4'b0001;
        4:       st_op = 4'b0010;
        5:       st_op = 4'b0100;
        6, 7:    st_op = 4'b1000;
        default: st_op = 4'($urandom_range(0, 15));
      endcase
      a = 64'h8000 + 64'($urandom_range(0, 31)) + (64'($urandom_range(0, 1)) << 40);
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      st_addr      = a;
      st_data      = {$urandom, $urandom};
      ld_chk_en    = $urandom_range(0, 1) == 1;
      ld_chk_addr  = 64'h8000 + 64'($urandom_range(0, 31)) + (64'($urandom_range(0, 1)) << 40);
      mem_wr_ready = $urandom_range(0, 3) != 0;
      step();
    end
    st_op = '0;
    mem_wr_ready = 1'b1;
    repeat (4) step();
    chk("final_empty", buf_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
